ff_bank: RTL and testbench

Parametrised bank of CH single-bit state channels. Each channel updates from its own input bit under a per-channel, run-time programmable next-state mode. The bank state is reduced to one status bit `z` by a programmable reduction, and a saturating counter records how many cycles that reduction was true. It generalises the fixed three-flop toggle/capture/set-invert NOR cell into a configurable building block for small control and status paths.

---
 rtl/ff_bank.sv | 119 +++++++++++
 tb/tb_ff_bank.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Bank of CH single-bit channels with per-channel next-state modes, a selectable
// reduction z and a saturating z-cycle counter. Define FF_BANK_ZREG_EN to register z.
module ff_bank #(
    parameter int CH    = 3,
    parameter int CNT_W = 8,
    parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    x,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic             cfg_red,
    input  logic [SEL_W-1:0] cfg_ch,
    input  logic [1:0]       cfg_val,
    output logic [CH-1:0]    q,
    output logic             z,
    output logic [CNT_W-1:0] zcnt
);

    typedef enum logic [1:0] {
        M_TOGGLE  = 2'b00,
        M_CAPTURE = 2'b01,
        M_SETINV  = 2'b10,
        M_D       = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        R_NOR = 2'b00,
        R_OR  = 2'b01,
        R_AND = 2'b10,
        R_XOR = 2'b11
    } red_e;

    logic [CH-1:0]      q_q, q_d;
    logic [CH-1:0][1:0] mode_q, mode_d;
    logic [1:0]         red_q, red_d;
    logic [CNT_W-1:0]   zcnt_q, zcnt_d;
    logic               r;

    always_comb begin
        case (red_q)
            R_NOR:   r = ~|q_q;
            R_OR:    r = |q_q;
            R_AND:   r = &q_q;
            default: r = ^q_q;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        mode_d = mode_q;
        red_d  = red_q;
        zcnt_d = zcnt_q;

        // Channel update always uses the mode latched before this edge.
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            for (int i = 0; i < CH; i++) begin
                case (mode_q[i])
                    M_TOGGLE:  q_d[i] = x[i] ^ q_q[i];
                    M_CAPTURE: q_d[i] = x[i] & ~q_q[i];
                    M_SETINV:  q_d[i] = x[i] | ~q_q[i];
                    default:   q_d[i] = x[i];
                endcase
            end
        end

        if (cfg_we) begin
            if (cfg_red)
                red_d = cfg_val;
            else if (int'(cfg_ch) < CH)
                mode_d[cfg_ch] = cfg_val;
        end

        if (clr)
            zcnt_d = '0;
        else if (r && (zcnt_q != {CNT_W{1'b1}}))
            zcnt_d = zcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            red_q  <= R_NOR;
            zcnt_q <= '0;
            for (int i = 0; i < CH; i++)
                mode_q[i] <= 2'(i % 3);
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            red_q  <= red_d;
            zcnt_q <= zcnt_d;
        end
    end

`ifdef FF_BANK_ZREG_EN
    logic z_q, z_d;

    always_comb z_d = r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            z_q <= 1'b1;
        else
            z_q <= z_d;
    end

    assign z = z_q;
`else
    assign z = r;
`endif

    assign q    = q_q;
    assign zcnt = zcnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank (CH=3, CNT_W=3); z expectations follow FF_BANK_ZREG_EN.
module tb_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] x;
    logic       en, clr, cfg_we, cfg_red;
    logic [1:0] cfg_ch, cfg_val;
    logic [2:0] q;
    logic       z;
    logic [2:0] zcnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FF_BANK_ZREG_EN
    localparam bit ZREG = 1'b1;
`else
    localparam bit ZREG = 1'b0;
`endif

    ff_bank #(.CH(3), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
        .cfg_we(cfg_we), .cfg_red(cfg_red), .cfg_ch(cfg_ch), .cfg_val(cfg_val),
        .q(q), .z(z), .zcnt(zcnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // zc: expected combinational z, zr: expected registered z
    task automatic chk(input string nm, input logic [2:0] eq, input logic [2:0] ec,
                       input logic zc, input logic zr);
        logic ez;
        ez = ZREG ? zr : zc;
        n_cmp++;
        if (q !== eq) begin
            n_err++;
            $display("FAIL %s q: got %b want %b", nm, q, eq);
        end
        n_cmp++;
        if (zcnt !== ec) begin
            n_err++;
            $display("FAIL %s zcnt: got %0d want %0d", nm, zcnt, ec);
        end
        n_cmp++;
        if (z !== ez) begin
            n_err++;
            $display("FAIL %s z: got %b want %b", nm, z, ez);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; x = '0; en = 0; clr = 0; cfg_we = 0; cfg_red = 0;
        cfg_ch = '0; cfg_val = '0;
        #3;
        chk("reset", 3'b000, 3'd0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_default_modes();
        en = 1; x = 3'b111;
        step(); chk("dflt_e1", 3'b111, 3'd1, 1'b0, 1'b1);
        step(); chk("dflt_e2", 3'b100, 3'd1, 1'b0, 1'b0);
        step(); chk("dflt_e3", 3'b111, 3'd1, 1'b0, 1'b0);
    endtask

    task automatic test_mode_collision();
        cfg_we = 1; cfg_red = 0; cfg_ch = 2'd0; cfg_val = 2'b11; en = 1; x = 3'b001;
        step(); chk("coll_old_mode", 3'b000, 3'd1, 1'b1, 1'b0);
        cfg_we = 0;
        step(); chk("coll_new_mode", 3'b101, 3'd2, 1'b0, 1'b1);
    endtask

    task automatic test_reduction();
        cfg_we = 1; cfg_red = 1; cfg_val = 2'b10; en = 0;
        step(); chk("red_and_wr", 3'b101, 3'd2, 1'b0, 1'b0);
        cfg_we = 0; en = 1; x = 3'b111;
        step(); chk("red_and_q111", 3'b111, 3'd2, 1'b1, 1'b0);
        en = 0;
        step(); chk("red_and_inc1", 3'b111, 3'd3, 1'b1, 1'b1);
        step(); chk("red_and_inc2", 3'b111, 3'd4, 1'b1, 1'b1);
        cfg_we = 1; cfg_red = 0; cfg_ch = 2'd1; cfg_val = 2'b11;
        step(); chk("red_mode1_d", 3'b111, 3'd5, 1'b1, 1'b1);
        cfg_red = 1; cfg_val = 2'b11; en = 1; x = 3'b110;
        step(); chk("red_xor_wr", 3'b110, 3'd6, 1'b0, 1'b1);
        cfg_we = 0; en = 0;
        step(); chk("red_xor_lag", 3'b110, 3'd6, 1'b0, 1'b0);
    endtask

    task automatic test_saturation_clear();
        cfg_we = 1; cfg_red = 1; cfg_val = 2'b01;
        step(); chk("sat_or_wr", 3'b110, 3'd6, 1'b1, 1'b0);
        cfg_we = 0;
        step(); chk("sat_first", 3'b110, 3'd7, 1'b1, 1'b1);
        repeat (9) step();
        chk("sat_held", 3'b110, 3'd7, 1'b1, 1'b1);
        clr = 1; en = 1; x = 3'b111;
        step(); chk("clr", 3'b000, 3'd0, 1'b0, 1'b1);
        clr = 0; en = 0;
        step(); chk("clr_z_lag", 3'b000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_invalid_hold();
        cfg_we = 1; cfg_red = 0; cfg_ch = 2'd3; cfg_val = 2'b01;
        step(); chk("bad_ch_wr", 3'b000, 3'd0, 1'b0, 1'b0);
        cfg_we = 0; en = 1; x = 3'b011;
        step(); chk("bad_ch_nochg", 3'b111, 3'd0, 1'b1, 1'b0);
        en = 0; x = 3'b000;
        step(); chk("hold1", 3'b111, 3'd1, 1'b1, 1'b1);
        x = 3'b111;
        step(); chk("hold2", 3'b111, 3'd2, 1'b1, 1'b1);
        x = 3'b010;
        step(); chk("hold3", 3'b111, 3'd3, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b0;
        #1 chk("mid_reset", 3'b000, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1; en = 1; x = 3'b111;
        step(); chk("post_rst_e1", 3'b111, 3'd1, 1'b0, 1'b1);
        step(); chk("post_rst_e2", 3'b100, 3'd1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_default_modes();
        test_mode_collision();
        test_reduction();
        test_saturation_clear();
        test_invalid_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
